sub_bytes_pipe: RTL and testbench
=================================

Name: sub_bytes_pipe

Overview:
- Parametrised, pipelined AES SubBytes engine; replaces the fixed 32-bit combinational inverse-substitution block.
- Processes LANES bytes per beat. Forward or inverse S-box is selected per transaction.
- Has valid/ready handshakes on both sides.
- Sits between the round-state register and ShiftRows/InvShiftRows in the round datapath, and is shared by the encrypt and decrypt paths.

Parameters:
- LANES, 4, bytes substituted per beat (1..16; 16 = full 128-bit state).
- TAG_W, 4, width of opaque sideband tag carried alongside data (>=1).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  engine can accept a beat this cycle.
- in_data  in  8*LANES  bytes; lane i = in_data[8i+7:8i].
- in_inv  in  1  0 = forward S-box, 1 = inverse S-box, for this beat.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  8*LANES  substituted bytes, same lane order.
- out_tag  out  TAG_W  tag of the beat.
- busy  out  1  any pipeline stage holds a beat.

Behaviour:
- Two register stages.
  - S0 captures in_data/in_inv/in_tag.
  - S1 holds the looked-up bytes.
  - Lookup is combinational between S0 and S1.
- Stage flags: v0, v1.
- Transfers:
  - out fires = out_valid & out_ready.
  - adv1 = v0 & (!v1 | out_ready).
  - in_ready = !v0 | adv1.
  - in fires = in_valid & in_ready.
- Latency: a beat accepted at cycle N appears on out_valid at cycle N+2 when not stalled.
- Throughput: 1 beat/cycle sustained with out_ready held high.
- Stalls:
  - out_ready low holds S1 stable; out_data/out_tag must not change while out_valid & !out_ready.
  - S0 fills, then in_ready drops.
  - No beat is dropped or duplicated.
- Simultaneous events:
  - With both stages full and out_ready=1, S1 takes S0 and S0 takes the new input in the same cycle.
- Mode is per beat: consecutive beats may alternate in_inv with no bubble.
- Lanes are independent. LANES=1 and LANES=16 must synthesise.
- busy = v0 | v1.
- Reset (rst_n=0 at a clock edge):
  - v0 = v1 = 0.
  - out_valid = 0, out_data = 0, out_tag = 0, busy = 0.
  - in_ready = 1 from the first cycle after reset releases.
- Reset mid-operation discards all in-flight beats. No partial output.
- Data registers need not be reset apart from out_data/out_tag, which must read 0 after reset.
- in_data/in_inv/in_tag are sampled only when in fires. X on them otherwise must not propagate.

Optional Feature:
- Macro SUB_BYTES_PARITY_EN.
- Defined:
  - Adds output out_par [LANES-1:0].
  - out_par[i] = even parity (XOR reduction) of out_data lane i, registered in S1 alongside data.
  - Reset value 0.
  - Adds input in_par [LANES-1:0], checked at S0 capture.
  - On mismatch, sticky output par_err (1 bit) sets and clears only on reset.
  - The beat still proceeds.
- Undefined: ports out_par, in_par, par_err do not exist; no parity logic.

Decomposition:
- Package aes_pkg:
  - SBOX and INV_SBOX as 256-entry byte constant arrays.
  - Typedef byte_t (8-bit).
  - Localparam AES_BLOCK_BYTES = 16.
- Sub-module aes_sbox_byte:
  - Inputs: 8-bit byte, inv select. Output: 8-bit result.
  - Purely combinational lookup into the package tables.
  - Instantiated LANES times via generate.

Test Plan:
- Forward word: LANES=4, in_inv=0, in_data=0x00112233, out_ready=1 -> two cycles later out_data=0x638293c3, out_tag echoed.
- Inverse word: in_inv=1, in_data=0x637c777b -> out_data=0x00010203. Also 0xed -> 0x53 and 0x00 -> 0x52 per lane.
- Alternating mode stream: 256 back-to-back beats cycling all byte values, in_inv toggling each beat, out_ready=1 -> 1 beat/cycle, each result matches the model, and fwd-then-inv round trip returns the original.
- Back-pressure: hold out_ready=0 for 5 cycles after 3 beats offered -> in_ready falls after 2 accepted, out_data stable, all 3 beats delivered in order once out_ready=1.
- Reset mid-stream: assert rst_n=0 with v0=v1=1 -> next cycle out_valid=0, busy=0, out_data=0, in_ready=1. No stale beat ever emerges.
- Parity (SUB_BYTES_PARITY_EN): in_data=0x00000001 with correct in_par=4'b0001 -> out_par matches out_data parity, par_err=0. Flip in_par[0] -> par_err=1 and stays set until reset.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES byte-substitution constants: forward and inverse S-box tables.
package aes_pkg;

    typedef logic [7:0] byte_t;

    localparam int unsigned AES_BLOCK_BYTES = 16;

    localparam byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam byte_t INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/aes_sbox_byte.sv
// Single-byte forward/inverse AES S-box, purely combinational table lookup.
module aes_sbox_byte
    import aes_pkg::*;
(
    input  logic [7:0] data_i,
    input  logic       inv_i,
    output logic [7:0] data_o
);

    always_comb begin
        data_o = inv_i ? INV_SBOX[data_i] : SBOX[data_i];
    end

endmodule

// File: rtl/sub_bytes_pipe.sv
// Two-stage valid/ready AES SubBytes engine, LANES bytes per beat, per-beat fwd/inv.
// Optional lane parity (in_par check, out_par, sticky par_err) under SUB_BYTES_PARITY_EN.
module sub_bytes_pipe
    import aes_pkg::*;
#(
    parameter int unsigned LANES = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*LANES-1:0] in_data,
    input  logic               in_inv,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*LANES-1:0] out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic               busy
`ifdef SUB_BYTES_PARITY_EN
    ,
    input  logic [LANES-1:0]   in_par,
    output logic [LANES-1:0]   out_par,
    output logic               par_err
`endif
);

    logic               v0_q, v0_d;
    logic               v1_q, v1_d;
    logic               adv1;
    logic               in_fire;
    logic [8*LANES-1:0] s0_data_q;
    logic               s0_inv_q;
    logic [TAG_W-1:0]   s0_tag_q;
    logic [8*LANES-1:0] s1_data_q, s1_data_d;
    logic [TAG_W-1:0]   s1_tag_q, s1_tag_d;
    logic [8*LANES-1:0] sub_data;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        aes_sbox_byte u_sbox (
            .data_i (s0_data_q[8*gi +: 8]),
            .inv_i  (s0_inv_q),
            .data_o (sub_data[8*gi +: 8])
        );
    end

    always_comb begin
        adv1      = v0_q & (~v1_q | out_ready);
        in_ready  = ~v0_q | adv1;
        in_fire   = in_valid & in_ready;
        v0_d      = in_fire | (v0_q & ~adv1);
        v1_d      = adv1 | (v1_q & ~out_ready);
        s1_data_d = adv1 ? sub_data : s1_data_q;
        s1_tag_d  = adv1 ? s0_tag_q : s1_tag_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v0_q      <= 1'b0;
            v1_q      <= 1'b0;
            s1_data_q <= '0;
            s1_tag_q  <= '0;
        end else begin
            v0_q      <= v0_d;
            v1_q      <= v1_d;
            s1_data_q <= s1_data_d;
            s1_tag_q  <= s1_tag_d;
        end
    end

    // S0 payload is only meaningful while v0_q is set, so it loads on accept and needs no reset.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            s0_data_q <= in_data;
            s0_inv_q  <= in_inv;
            s0_tag_q  <= in_tag;
        end
    end

    assign out_valid = v1_q;
    assign out_data  = s1_data_q;
    assign out_tag   = s1_tag_q;
    assign busy      = v0_q | v1_q;

`ifdef SUB_BYTES_PARITY_EN
    logic [LANES-1:0] in_par_calc;
    logic [LANES-1:0] sub_par;
    logic [LANES-1:0] out_par_q, out_par_d;
    logic             par_err_q, par_err_d;

    always_comb begin
        in_par_calc = '0;
        sub_par     = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            in_par_calc[i] = ^in_data[8*i +: 8];
            sub_par[i]     = ^sub_data[8*i +: 8];
        end
        out_par_d = adv1 ? sub_par : out_par_q;
        par_err_d = par_err_q | (in_fire & (in_par_calc != in_par));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_par_q <= '0;
            par_err_q <= 1'b0;
        end else begin
            out_par_q <= out_par_d;
            par_err_q <= par_err_d;
        end
    end

    assign out_par = out_par_q;
    assign par_err = par_err_q;
`endif

endmodule

// File: tb/tb_sub_bytes_pipe.sv
// Directed self-checking bench for sub_bytes_pipe (LANES=4, TAG_W=4).
module tb_sub_bytes_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_inv;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_tag;
    logic        busy;
`ifdef SUB_BYTES_PARITY_EN
    logic [3:0]  in_par;
    logic [3:0]  out_par;
    logic        par_err;
`endif

    sub_bytes_pipe #(.LANES(4), .TAG_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_inv    (in_inv),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .busy      (busy)
`ifdef SUB_BYTES_PARITY_EN
        ,
        .in_par    (in_par),
        .out_par   (out_par),
        .par_err   (par_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tag;
    } beat_t;

    beat_t       exp_q[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned stalls = 0;
    logic [7:0]  fwd_tbl [256];
    logic [7:0]  inv_tbl [256];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference S-box derived from GF(2^8) inversion plus the affine map.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    task automatic build_tables();
        logic [7:0] xi;
        logic [7:0] yi;
        for (int x = 0; x < 256; x++) begin
            xi = 8'(x);
            yi = 8'h00;
            if (x != 0) begin
                for (int y = 1; y < 256; y++) begin
                    if (gf_mul(xi, 8'(y)) == 8'h01) yi = 8'(y);
                end
            end
            fwd_tbl[x] = affine(yi);
            inv_tbl[fwd_tbl[x]] = xi;
        end
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] d, input logic inv);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = inv ? inv_tbl[d[8*i +: 8]] : fwd_tbl[d[8*i +: 8]];
        end
        return r;
    endfunction

    // Offers one beat starting #1 after a posedge; returns #1 after the accepting edge.
    task automatic send_beat(input logic [31:0] d, input logic inv, input logic [3:0] tag,
                             input logic [31:0] exp, input bit track);
        bit          done;
        int unsigned waited;
        beat_t       b;
        done   = 1'b0;
        waited = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_inv   = inv;
        in_tag   = tag;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1'b1;
                if (track) begin
                    b.data = exp;
                    b.tag  = tag;
                    exp_q.push_back(b);
                end
            end else if (waited >= 50) begin
                check("accept_timeout", {31'b0, in_ready}, 32'd1);
                done = 1'b1;
            end else begin
                waited++;
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", {31'b0, out_valid}, 32'd0);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                check("out_data", out_data, e.data);
                check("out_tag", {28'b0, out_tag}, {28'b0, e.tag});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] dj;
        logic [31:0] fj;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_inv    = 1'b0;
        in_tag    = '0;
        out_ready = 1'b1;
`ifdef SUB_BYTES_PARITY_EN
        in_par    = '0;
`endif
        build_tables();

        @(posedge clk);
        tick(2);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_tag", {28'b0, out_tag}, 32'h0);
        rst_n = 1'b1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Forward word with exact two-cycle latency.
        send_beat(32'h00112233, 1'b0, 4'h5, 32'h638293c3, 1'b1);
        check("lat_n1_valid", {31'b0, out_valid}, 32'd0);
        check("lat_n1_busy", {31'b0, busy}, 32'd1);
        tick(1);
        check("lat_n2_valid", {31'b0, out_valid}, 32'd1);
        check("fwd_word", out_data, 32'h638293c3);
        check("fwd_tag", {28'b0, out_tag}, 32'h5);
        tick(2);

        send_beat(32'h637c777b, 1'b1, 4'ha, 32'h00010203, 1'b1);
        send_beat(32'h00ed00ed, 1'b1, 4'hb, 32'h52535253, 1'b1);
        tick(4);
        check("idle_drained", exp_q.size(), 32'd0);

        // Alternating stream: even beats forward, odd beats invert the previous forward result.
        stalls = 0;
        for (int k = 0; k < 256; k++) begin
            if (k % 2 == 0) begin
                for (int i = 0; i < 4; i++) dj[8*i +: 8] = 8'(k / 2 + 64 * i);
                fj = model_word(dj, 1'b0);
                send_beat(dj, 1'b0, 4'(k), fj, 1'b1);
            end else begin
                send_beat(fj, 1'b1, 4'(k), dj, 1'b1);
            end
        end
        check("stream_stalls", stalls, 32'd0);
        tick(2);
        check("stream_drained", exp_q.size(), 32'd0);
        check("stream_idle", {31'b0, out_valid}, 32'd0);

        // Back-pressure: two beats fill the pipe, the third waits.
        out_ready = 1'b0;
        send_beat(32'h00000001, 1'b0, 4'h1, 32'h6363637c, 1'b1);
        send_beat(32'h53535353, 1'b0, 4'h2, 32'hedededed, 1'b1);
        in_valid = 1'b1;
        in_data  = 32'h00000053;
        in_inv   = 1'b0;
        in_tag   = 4'h3;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
            check("bp_out_data", out_data, 32'h6363637c);
            check("bp_out_tag", {28'b0, out_tag}, 32'h1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send_beat(32'h00000053, 1'b0, 4'h3, 32'h636363ed, 1'b1);
        tick(4);
        check("bp_drained", exp_q.size(), 32'd0);

        // Reset with both stages full discards everything.
        out_ready = 1'b0;
        send_beat(32'hdeadbeef, 1'b0, 4'h7, 32'h0, 1'b0);
        send_beat(32'hcafef00d, 1'b1, 4'h8, 32'h0, 1'b0);
        check("mid_busy", {31'b0, busy}, 32'd1);
        check("mid_full_valid", {31'b0, out_valid}, 32'd1);
        rst_n = 1'b0;
        tick(1);
        check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_data", out_data, 32'h0);
        check("mid_rst_ready", {31'b0, in_ready}, 32'd1);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick(6);
        check("mid_no_stale", {31'b0, out_valid}, 32'd0);

`ifdef SUB_BYTES_PARITY_EN
        in_par = 4'b0001;
        send_beat(32'h00000001, 1'b0, 4'h4, 32'h6363637c, 1'b1);
        tick(1);
        check("par_out", {28'b0, out_par}, 32'h1);
        check("par_err_clean", {31'b0, par_err}, 32'd0);
        in_par = 4'b0000;
        send_beat(32'h00000001, 1'b0, 4'h6, 32'h6363637c, 1'b1);
        tick(1);
        check("par_err_set", {31'b0, par_err}, 32'd1);
        in_par = 4'b0001;
        send_beat(32'h00000001, 1'b0, 4'h9, 32'h6363637c, 1'b1);
        tick(3);
        check("par_err_sticky", {31'b0, par_err}, 32'd1);
        rst_n = 1'b0;
        tick(1);
        check("par_err_rst", {31'b0, par_err}, 32'd0);
        check("par_out_rst", {28'b0, out_par}, 32'h0);
        rst_n = 1'b1;
        tick(1);
`endif

        check("final_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
